// File: rtl/yarc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : yarc_pkg
//  Brief    : Shared types and constants for the execute-stage pipe control.
//  Revision : 1.0 - initial release
// ============================================================================
package yarc_pkg;

    localparam int REG_W = 5;
    localparam int IT_W  = 10;

    // One-hot instruction class bit positions
    localparam int IT_REG    = 0;
    localparam int IT_IMM    = 1;
    localparam int IT_STORE  = 2;
    localparam int IT_LOAD   = 3;
    localparam int IT_BRANCH = 4;
    localparam int IT_LUI    = 5;
    localparam int IT_AUIPC  = 6;
    localparam int IT_JAL    = 7;
    localparam int IT_JALR   = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    // jmp marks jal/jalr, which redirect unconditionally once in MEM
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
        logic             ctl;
        logic             jmp;
    } slot_t;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
    } src_t;

endpackage
`default_nettype wire

// File: rtl/ex_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ex_fwd_unit
//  Brief    : Operand forwarding select for one EX source; MEM beats WB.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_fwd_unit
    import yarc_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  logic             mem_v,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_v,
    input  logic             wb_wr,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);

    logic w_live;
    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired zero and never takes a bypass
    assign w_live    = used && (rs != '0);
    assign w_mem_hit = w_live && mem_v && mem_wr && (mem_rd == rs);
    assign w_wb_hit  = w_live && wb_v && wb_wr && (wb_rd == rs);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ex_pipe_ctrl
//  Brief    : EX/MEM/WB slot tracking, load-use stall, forwarding, redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_pipe_ctrl
    import yarc_pkg::*;
#(
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [IT_W-1:0]          id_instype,
    input  logic [$clog2(NREG)-1:0]  id_rs1,
    input  logic [$clog2(NREG)-1:0]  id_rs2,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [$clog2(NREG)-1:0]  id_rd,
    input  logic                     branch,
    input  logic                     mem_ready,
    output logic                     if_stall,
    output logic                     id_stall,
    output logic                     id_flush,
    output logic                     ex_valid,
    output logic [1:0]               fwd_rs1_sel,
    output logic [1:0]               fwd_rs2_sel,
    output logic                     redirect,
    output logic [CNTW-1:0]          stall_cnt,
    output logic [CNTW-1:0]          flush_cnt
);

    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    slot_t           r_ex, r_mem, r_wb;
    src_t            r_src;
    slot_t           w_id_slot, w_ex_to_mem;
    src_t            w_id_src;
    logic            w_lu, w_rdt, w_bubble;
    logic [CNTW-1:0] r_stall_cnt, r_flush_cnt;
    logic            w_unused;

    always_comb begin
        w_id_slot     = '0;
        w_id_slot.v   = id_valid;
        w_id_slot.rd  = id_rd;
        w_id_slot.wr  = (id_instype[IT_REG]   || id_instype[IT_IMM]  ||
                         id_instype[IT_LOAD]  || id_instype[IT_LUI]  ||
                         id_instype[IT_AUIPC] || id_instype[IT_JAL]  ||
                         id_instype[IT_JALR]) && (id_rd != '0);
        w_id_slot.ld  = id_instype[IT_LOAD];
        w_id_slot.ctl = id_instype[IT_BRANCH] || id_instype[IT_JAL] ||
                        id_instype[IT_JALR];
        w_id_slot.jmp = id_instype[IT_JAL] || id_instype[IT_JALR];

        w_id_src          = '0;
        w_id_src.rs1      = id_rs1;
        w_id_src.rs2      = id_rs2;
        w_id_src.rs1_used = id_valid && id_rs1_used;
        w_id_src.rs2_used = id_valid && id_rs2_used;

        w_ex_to_mem   = r_ex;
        w_ex_to_mem.v = r_ex.v && !w_rdt;
    end

    // wr already excludes rd==0, so x0 never stalls
    assign w_lu = id_valid && r_ex.v && r_ex.ld && r_ex.wr &&
                  ((id_rs1_used && (id_rs1 == r_ex.rd)) ||
                   (id_rs2_used && (id_rs2 == r_ex.rd)));
    assign w_rdt    = mem_ready && r_mem.v && r_mem.ctl && (r_mem.jmp || branch);
    assign w_bubble = w_lu || w_rdt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_src       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (mem_ready) begin
                r_wb  <= r_mem;
                r_mem <= w_ex_to_mem;
                r_ex  <= w_bubble ? '0 : w_id_slot;
                r_src <= w_bubble ? '0 : w_id_src;
                if (w_lu && !w_rdt) begin
                    r_stall_cnt <= r_stall_cnt + c_cnt_one;
                end
                if (w_rdt) begin
                    r_flush_cnt <= r_flush_cnt + c_cnt_one;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if_stall    = 1'b0;
        id_stall    = 1'b0;
        id_flush    = 1'b0;
        redirect    = 1'b0;
        case (r_state)
            RUN, MEMWAIT: begin
                if (!mem_ready) begin
                    w_state_nxt = MEMWAIT;
                end else if (w_lu && !w_rdt) begin
                    w_state_nxt = LDSTALL;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            // EX holds the bubble; the consumer is free to advance
            LDSTALL: w_state_nxt = mem_ready ? RUN : MEMWAIT;
            default: w_state_nxt = RUN;
        endcase
        if (!mem_ready || (w_lu && !w_rdt)) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end
        if (w_rdt) begin
            id_flush = 1'b1;
            redirect = 1'b1;
        end
    end

    ex_fwd_unit u_fwd_rs1 (
        .rs     (r_src.rs1),
        .used   (r_src.rs1_used),
        .mem_v  (r_mem.v),
        .mem_wr (r_mem.wr),
        .mem_rd (r_mem.rd),
        .wb_v   (r_wb.v),
        .wb_wr  (r_wb.wr),
        .wb_rd  (r_wb.rd),
        .sel    (fwd_rs1_sel)
    );

    ex_fwd_unit u_fwd_rs2 (
        .rs     (r_src.rs2),
        .used   (r_src.rs2_used),
        .mem_v  (r_mem.v),
        .mem_wr (r_mem.wr),
        .mem_rd (r_mem.rd),
        .wb_v   (r_wb.v),
        .wb_wr  (r_wb.wr),
        .wb_rd  (r_wb.rd),
        .sel    (fwd_rs2_sel)
    );

    assign ex_valid  = r_ex.v;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    assign w_unused = ^{r_wb.ld, r_wb.ctl, r_wb.jmp, r_mem.ld,
                        id_instype[IT_STORE], id_instype[IT_W-1]};

    // A load result can only reach EX from WB; the stall guarantees it
    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (rst)
        !(r_mem.v && r_mem.ld && r_mem.wr && r_ex.v &&
          ((r_src.rs1_used && (r_src.rs1 == r_mem.rd)) ||
           (r_src.rs2_used && (r_src.rs2 == r_mem.rd)))));

endmodule
`default_nettype wire

// File: doc/ex_pipe_ctrl.md
# ex_pipe_ctrl

Pipeline controller for the execute stage of the pipelined core. It tracks the instructions in the EX, MEM and WB slots and detects load-use hazards, inserting one bubble when one occurs. It drives the operand forwarding selects for the instruction in EX and kills wrong-path instructions when a branch or jump resolves. It sits between decode and the execute unit and gates the execute unit's inputs via `ex_valid`.

## Interface
- `NREG`, 32: architectural register count; `rd`/`rs` width is log2(NREG) = 5.
- `CNTW`, 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_instype` in 10: one-hot instruction class. Bits: 0 reg, 1 imm, 2 store, 3 load, 4 branch, 5 lui, 6 auipc, 7 jal, 8 jalr.
- `id_rs1`, `id_rs2` in 5: source register addresses.
- `id_rs1_used`, `id_rs2_used` in 1: the instruction reads that source.
- `id_rd` in 5: destination register address.
- `branch` in 1: registered branch-taken flag from the execute unit; refers to the MEM-slot instruction.
- `mem_ready` in 1: data memory can advance; 0 freezes the whole pipeline.
- `if_stall`, `id_stall` out 1: hold the PC and the IF/ID register.
- `id_flush` out 1: replace the ID→EX transfer with a bubble.
- `ex_valid` out 1: EX slot holds a live instruction.
- `fwd_rs1_sel`, `fwd_rs2_sel` out 2: forwarding select for the EX operands. 00 = register file, 01 = MEM (`aluout1`), 10 = WB.
- `redirect` out 1: one-cycle pulse; fetch loads the target from MEM-slot `aluout1`.
- `stall_cnt`, `flush_cnt` out CNTW: performance counters.

## Operation
- Slot record kept for each of EX, MEM and WB: `v`, `rd`, `wr`, `ld`, `ctl`, plus `rs1`/`rs2`/`used` for EX only.
  - `wr` = instype bit 0, 1, 3, 5, 6, 7 or 8 set, and `rd != 0`.
  - `ld` = instype bit 3.
  - `ctl` = instype bit 4, 7 or 8.
- Load-use hazard (`lu`) = `id_valid` & EX.`v` & EX.`ld` & EX.`wr` & (`rs1_used` & `id_rs1`==EX.`rd` | `rs2_used` & `id_rs2`==EX.`rd`).
- Redirect (`rd_t`) = `mem_ready` & MEM.`v` & MEM.`ctl` & (instype bit 7 or 8 | `branch`).
  - Jumps (jal, jalr) are always taken.
- Forwarding for the EX operand rsN, with used and rsN != 0:
  - 01 if MEM.`v` & MEM.`wr` & MEM.`rd`==rsN;
  - else 10 if the same match holds against WB;
  - else 00. MEM has priority over WB.
- Register x0 never forwards and never causes a hazard.
- State machine, encoding in the package:
  - RUN: normal advance. `lu` & !`rd_t` → LDSTALL. !`mem_ready` → MEMWAIT.
  - LDSTALL (exactly 1 cycle): IF/ID held, bubble into EX. Then → RUN; → MEMWAIT if `mem_ready`=0.
  - MEMWAIT: all slots and outputs frozen; `if_stall`=`id_stall`=1. Hazard re-evaluation resumes when `mem_ready`=1 → RUN.
- Advance on each enabled cycle: ID→EX (bubble if `lu` or `id_flush`), EX→MEM, MEM→WB.
- On `rd_t`:
  - `redirect`=1 and `id_flush`=1;
  - the EX-slot record moves to MEM with `v`=0;
  - the ID instruction is dropped;
  - `flush_cnt` += 1.
- Simultaneous `rd_t` and `lu`: redirect wins, no stall, `stall_cnt` unchanged.
- `stall_cnt` += 1 per load-use bubble only. Memory-wait cycles are not counted.
- Both counters wrap modulo 2^CNTW.

## Timing
- Reset values:
  - all slot `v` bits = 0; state RUN;
  - every output 0, counters included.
- Reset asserted mid-stall or mid-flush discards all in-flight state in that cycle.
- `fwd_*_sel` and `ex_valid` are combinational from registered slot state only.
- `if_stall`, `id_stall`, `id_flush` and `redirect` are combinational from the `id_*`, `branch` and `mem_ready` inputs plus state.
- Load-use penalty: exactly 1 bubble. The consumer then forwards from WB (sel 10).
- Branch/jump penalty: 2 killed instructions (the EX and ID slots at the redirect cycle).
- `redirect` is never asserted while `mem_ready`=0. It fires in the first cycle `mem_ready` returns to 1.
- Assertion: MEM.`ld` matching an EX source with MEM.`v` must never occur.

## Structure
- Shared package `yarc_pkg` holds:
  - instype bit index constants (`IT_REG` … `IT_JALR`);
  - `FWD_RF`/`FWD_MEM`/`FWD_WB` codes;
  - state enum `{RUN, LDSTALL, MEMWAIT}`;
  - the slot record typedef.
- Sub-module `ex_fwd_unit`: purely combinational compare of the EX sources against the MEM/WB slots. Instantiated once for rs1 and once for rs2.

## Test plan
- Back-to-back dependency, `add x5,x1,x2` then `add x6,x5,x3`: consumer in EX sees `fwd_rs1_sel`=01. With one unrelated instruction between them, it sees 10.
- `lw x6,0(x1)` then `add x7,x6,x1`: `if_stall`=`id_stall`=1 for exactly 1 cycle; `ex_valid`=0 the next cycle; consumer then gets `fwd_rs1_sel`=10; `stall_cnt`=1.
- Taken `beq` (`branch`=1 while it is in MEM): `redirect`=1 and `id_flush`=1 for 1 cycle; the next 2 instructions reach MEM with `v`=0; `flush_cnt`=1. A not-taken `beq` gives no redirect. A `jal` always redirects.
- `lw x0` followed by `add x1,x0,x0`: no stall, all forwarding selects 00.
- `mem_ready`=0 for 3 cycles while a load-use is pending: slots, selects and counters frozen. After release, exactly 1 bubble and `stall_cnt` increases by 1.
- `rst` pulsed the cycle after a redirect: the next cycle has all outputs 0, `ex_valid`=0 and state RUN.
